seg_scan: RTL and testbench

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_scan_if.sv | 14 +
 rtl/seg_scan.sv | 85 ++++++++
 tb/tb_seg_scan.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// rtl/seg_scan_if.sv - BCD capture and multiplexed display signals of the segment scanner
// master drives the value to show; slave is the scanner itself.
interface seg_scan_if;
   logic        bcd_valid;
   logic [35:0] bcd;
   logic        blank_en;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        ovf;

   modport master (output bcd_valid, bcd, blank_en, input an, seg, dp, ovf);
   modport slave  (input bcd_valid, bcd, blank_en, output an, seg, dp, ovf);
endinterface

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - eight-digit multiplexed seven-segment scanner for a nine-digit BCD value
// Each digit is lit for CLK_DIV cycles; outputs are registered one cycle behind idx/val.
module seg_scan #(
   parameter int CLK_DIV = 100000
) (
   input  logic     clk,
   input  logic     rst,
   seg_scan_if.slave bus
);

   localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div;
   logic [2:0]    idx;
   logic [31:0]   val;
   logic          ovf_q;
   logic [31:0]   upper;
   logic [3:0]    digit;
   logic [6:0]    seg_d;
   logic [7:0]    an_q;
   logic [6:0]    seg_q;
   logic          dp_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         div   <= '0;
         idx   <= 3'd0;
         val   <= 32'd0;
         ovf_q <= 1'b0;
      end else begin
         if (div == DIV_LAST) begin
            div <= '0;
            idx <= idx + 3'd1;
         end else begin
            div <= div + 1'b1;
         end
         if (bus.bcd_valid) begin
            val   <= bus.bcd[31:0];
            ovf_q <= (bus.bcd[35:32] != 4'd0);
         end
      end
   end

   // upper holds the current digit and everything more significant, so it doubles as the blanking test
   always_comb begin
      upper = val >> {idx, 2'b00};
      digit = upper[3:0];
      case (digit)
         4'd0:    seg_d = 7'h40;
         4'd1:    seg_d = 7'h79;
         4'd2:    seg_d = 7'h24;
         4'd3:    seg_d = 7'h30;
         4'd4:    seg_d = 7'h19;
         4'd5:    seg_d = 7'h12;
         4'd6:    seg_d = 7'h02;
         4'd7:    seg_d = 7'h78;
         4'd8:    seg_d = 7'h00;
         4'd9:    seg_d = 7'h10;
         default: seg_d = 7'h06;
      endcase
      if (ovf_q)
         seg_d = 7'h3F;
      else if (bus.blank_en && (idx != 3'd0) && (upper == 32'd0))
         seg_d = 7'h7F;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         an_q  <= 8'hFF;
         seg_q <= 7'h7F;
         dp_q  <= 1'b1;
      end else begin
         an_q  <= ~(8'b1 << idx);
         seg_q <= seg_d;
         dp_q  <= 1'b1;
      end
   end

   assign bus.an  = an_q;
   assign bus.seg = seg_q;
   assign bus.dp  = dp_q;
   assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - directed bench for seg_scan with CLK_DIV=4
// k counts rising edges since reset release; output after edge k shows digit ((k-1)/4) mod 8.
module tb_seg_scan;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;
   int   k = 0;

   seg_scan_if bus ();

   seg_scan #(.CLK_DIV(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      assert (act === exp)
      else begin
         failures++;
         $error("FAIL %s k=%0d got=%h expected=%h", tag, k, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.bcd_valid = 1'b0;
      step();
      step();
      rst = 1'b0;
      k = 0;
   endtask

   // segs packs the expected pattern for digits 7..0 as {d7,...,d0}
   task automatic scan(input string tag, input logic [55:0] segs, input int last_k);
      int i;
      logic [7:0] ea;
      while (k < last_k) begin
         step();
         i = ((k - 1) / 4) % 8;
         ea = ~(8'b1 << i);
         chk({tag, "_an"}, 32'(bus.an), 32'(ea));
         chk({tag, "_seg"}, 32'(bus.seg), 32'(segs[7*i +: 7]));
         chk({tag, "_dp"}, 32'(bus.dp), 32'd1);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.bcd_valid = 1'b0;
      bus.bcd = 36'h0;
      bus.blank_en = 1'b0;

      // reset state and first cycle after release
      do_reset();
      chk("rst_an", 32'(bus.an), 32'hFF);
      chk("rst_seg", 32'(bus.seg), 32'h7F);
      chk("rst_dp", 32'(bus.dp), 32'd1);
      chk("rst_ovf", 32'(bus.ovf), 32'd0);
      step();
      chk("rel_an", 32'(bus.an), 32'hFE);
      chk("rel_seg", 32'(bus.seg), 32'h40);

      // scenario 1: full scan of 12345678
      do_reset();
      bus.bcd = 36'h0_12345678;
      bus.bcd_valid = 1'b1;
      step();
      bus.bcd_valid = 1'b0;
      chk("s1_first_seg", 32'(bus.seg), 32'h40);
      scan("s1", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}, 33);

      // scenario 2: leading-zero blanking of 42, then blanking switched off
      do_reset();
      bus.blank_en = 1'b1;
      bus.bcd = 36'h0_00000042;
      bus.bcd_valid = 1'b1;
      step();
      bus.bcd_valid = 1'b0;
      chk("s2_zero_d0", 32'(bus.seg), 32'h40);
      scan("s2", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}, 32);
      bus.blank_en = 1'b0;
      scan("s2_noblank", {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h19, 7'h24}, 48);

      // scenario 3: overflow dashes, then cleared by a new strobe
      do_reset();
      bus.blank_en = 1'b1;
      bus.bcd = 36'h1_00000000;
      bus.bcd_valid = 1'b1;
      step();
      bus.bcd_valid = 1'b0;
      chk("s3_ovf_set", 32'(bus.ovf), 32'd1);
      scan("s3", {8{7'h3F}}, 32);
      bus.bcd = 36'h0_00000005;
      bus.bcd_valid = 1'b1;
      step();
      bus.bcd_valid = 1'b0;
      chk("s3_ovf_clr", 32'(bus.ovf), 32'd0);
      chk("s3_last_dash", 32'(bus.seg), 32'h3F);
      step();
      chk("s3_d0_an", 32'(bus.an), 32'hFE);
      chk("s3_d0_seg", 32'(bus.seg), 32'h12);
      bus.blank_en = 1'b0;

      // scenario 4: strobe coincides with the idx 3->4 advance
      do_reset();
      bus.bcd = 36'h0_11111111;
      bus.bcd_valid = 1'b1;
      step();
      bus.bcd_valid = 1'b0;
      scan("s4_old", {8{7'h79}}, 15);
      bus.bcd = 36'h0_22222222;
      bus.bcd_valid = 1'b1;
      step();
      bus.bcd_valid = 1'b0;
      chk("s4_d3_an", 32'(bus.an), 32'hF7);
      chk("s4_d3_seg", 32'(bus.seg), 32'h79);
      scan("s4_new", {8{7'h24}}, 32);

      // scenario 5: reset mid-scan at idx 5 with a simultaneous strobe
      do_reset();
      bus.bcd = 36'h0_12345678;
      bus.bcd_valid = 1'b1;
      step();
      bus.bcd_valid = 1'b0;
      scan("s5", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}, 21);
      rst = 1'b1;
      bus.bcd = 36'h1_99999999;
      bus.bcd_valid = 1'b1;
      step();
      chk("s5_rst_an", 32'(bus.an), 32'hFF);
      chk("s5_rst_seg", 32'(bus.seg), 32'h7F);
      chk("s5_rst_dp", 32'(bus.dp), 32'd1);
      chk("s5_rst_ovf", 32'(bus.ovf), 32'd0);
      rst = 1'b0;
      bus.bcd_valid = 1'b0;
      k = 0;
      step();
      chk("s5_rel_an", 32'(bus.an), 32'hFE);
      chk("s5_rel_seg", 32'(bus.seg), 32'h40);
      chk("s5_rel_ovf", 32'(bus.ovf), 32'd0);
      scan("s5_after", {8{7'h40}}, 12);

      // scenario 6: invalid BCD nibble shows E
      do_reset();
      bus.bcd = 36'h0_00000A00;
      bus.bcd_valid = 1'b1;
      step();
      bus.bcd_valid = 1'b0;
      scan("s6", {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h06, 7'h40, 7'h40}, 32);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
